// File: rtl/simple_fixed_point_signed_shift_add_multiplier_if.sv
// Operand/result handshake bundle for the shift-add fixed-point multiplier.
// The master drives the operands and the slave returns the product.
interface simple_fixed_point_signed_shift_add_multiplier_if #(
    parameter int DATA_WIDTH = 8
);
    logic                  i_valid;
    logic [DATA_WIDTH-1:0] i_a;
    logic [DATA_WIDTH-1:0] i_b;
    logic                  o_ready;
    logic                  o_valid;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_overflow;

    modport master (
        output i_valid, i_a, i_b,
        input  o_ready, o_valid, o_data, o_overflow
    );

    modport slave (
        input  i_valid, i_a, i_b,
        output o_ready, o_valid, o_data, o_overflow
    );
endinterface

// File: rtl/simple_fixed_point_signed_shift_add_multiplier.sv
// Sequential signed Q(W-F).F multiplier: one multiplier bit per clock on the
// operand magnitudes, then sign restore, truncate toward zero and saturate.
//
// state | meaning
// IDLE  | o_ready high, waiting for an operand pair
// RUN   | W shift-add steps over the multiplier magnitude
// DONE  | one-cycle o_valid pulse with the registered result
module simple_fixed_point_signed_shift_add_multiplier #(
    parameter int DATA_WIDTH = 8,
    parameter int FRAC_BITS  = 4
) (
    input  logic i_clk,
    input  logic i_reset,
    simple_fixed_point_signed_shift_add_multiplier_if.slave bus
);
    localparam int W     = DATA_WIDTH;
    localparam int CNT_W = (W > 1) ? $clog2(W) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT  = CNT_W'(W - 1);
    localparam logic [2*W-1:0]   POS_LIMIT = {{(W+1){1'b0}}, {(W-1){1'b1}}};
    localparam logic [2*W-1:0]   NEG_LIMIT = {{W{1'b0}}, 1'b1, {(W-1){1'b0}}};
    localparam logic [W-1:0]     SAT_POS   = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]     SAT_NEG   = {1'b1, {(W-1){1'b0}}};

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state, state_nxt;
    logic [2*W-1:0]   mcand, acc, acc_nxt, mag;
    logic [W-1:0]     mplier, abs_a, abs_b, res_data;
    logic [CNT_W-1:0] count;
    logic             sign, res_ovf;

    // Magnitude of the most negative value is 2^(W-1), which fits unsigned.
    assign abs_a = bus.i_a[W-1] ? (W'(0) - bus.i_a) : bus.i_a;
    assign abs_b = bus.i_b[W-1] ? (W'(0) - bus.i_b) : bus.i_b;

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) state <= IDLE;
        else         state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (bus.i_valid) state_nxt = RUN;
            RUN:     if (count == LAST_BIT) state_nxt = DONE;
            DONE:    state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_comb begin
        acc_nxt = acc;
        if (mplier[0]) acc_nxt = acc + (mcand << count);
        mag      = acc_nxt >> FRAC_BITS;
        res_data = '0;
        res_ovf  = 1'b0;
        if (!sign) begin
            if (mag > POS_LIMIT) begin
                res_data = SAT_POS;
                res_ovf  = 1'b1;
            end else begin
                res_data = mag[W-1:0];
            end
        end else begin
            if (mag > NEG_LIMIT) begin
                res_data = SAT_NEG;
                res_ovf  = 1'b1;
            end else begin
                res_data = W'(0) - mag[W-1:0];
            end
        end
    end

    always_ff @(posedge i_clk or posedge i_reset) begin
        if (i_reset) begin
            mcand          <= '0;
            mplier         <= '0;
            acc            <= '0;
            count          <= '0;
            sign           <= 1'b0;
            bus.o_ready    <= 1'b1;
            bus.o_valid    <= 1'b0;
            bus.o_data     <= '0;
            bus.o_overflow <= 1'b0;
        end else begin
            bus.o_ready <= (state_nxt == IDLE);
            bus.o_valid <= (state_nxt == DONE);
            case (state)
                IDLE: begin
                    if (bus.i_valid) begin
                        mcand  <= {{W{1'b0}}, abs_a};
                        mplier <= abs_b;
                        sign   <= bus.i_a[W-1] ^ bus.i_b[W-1];
                        acc    <= '0;
                        count  <= '0;
                    end
                end
                RUN: begin
                    acc    <= acc_nxt;
                    mplier <= mplier >> 1;
                    count  <= count + 1'b1;
                    if (count == LAST_BIT) begin
                        bus.o_data     <= res_data;
                        bus.o_overflow <= res_ovf;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_simple_fixed_point_signed_shift_add_multiplier.sv
// Directed and random checks of the shift-add multiplier at W=8, F=4,
// including latency, handshake spacing and mid-operation reset.
module tb_simple_fixed_point_signed_shift_add_multiplier;
    localparam int W = 8;
    localparam int F = 4;

    logic i_clk;
    logic i_reset;
    int   errors = 0;
    int   checks = 0;

    simple_fixed_point_signed_shift_add_multiplier_if #(.DATA_WIDTH(W)) bus ();

    simple_fixed_point_signed_shift_add_multiplier #(
        .DATA_WIDTH(W),
        .FRAC_BITS (F)
    ) dut (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .bus    (bus)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    // Reference: full signed integer product, magnitude >> F, saturate.
    function automatic void model(input logic [7:0] a, input logic [7:0] b,
                                  output logic [7:0] d, output logic o);
        int p;
        int m;
        p = $signed(a) * $signed(b);
        m = ((p < 0) ? -p : p) >>> F;
        o = 1'b0;
        if (p >= 0) begin
            if (m > 127) begin d = 8'h7F; o = 1'b1; end
            else d = 8'(m);
        end else begin
            if (m > 128) begin d = 8'h80; o = 1'b1; end
            else d = 8'(-m);
        end
    endfunction

    // Issue one operation from an idle DUT; operands are scrambled after accept.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b,
                          output logic [7:0] d, output logic o,
                          output int lat, output logic pulse_ok);
        int guard = 0;
        while (!bus.o_ready && guard < 30) begin
            @(posedge i_clk); #1;
            guard++;
        end
        bus.i_a = a; bus.i_b = b; bus.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0; bus.i_a = ~a; bus.i_b = a ^ b;
        lat = 1;
        while (!bus.o_valid && lat < 30) begin
            @(posedge i_clk); #1;
            lat++;
        end
        d = bus.o_data;
        o = bus.o_overflow;
        @(posedge i_clk); #1;
        pulse_ok = !bus.o_valid && bus.o_ready;
    endtask

    task automatic test_reset();
        i_reset = 1'b1;
        bus.i_valid = 1'b1; bus.i_a = 8'h7F; bus.i_b = 8'h7F;
        repeat (3) @(posedge i_clk);
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 8'h00 || bus.o_overflow !== 1'b0)
            begin errors++; $display("FAIL reset_values: ready=%b valid=%b data=%h ovf=%b, want 1 0 00 0",
                bus.o_ready, bus.o_valid, bus.o_data, bus.o_overflow); end
        bus.i_valid = 1'b0;
        #2 i_reset = 1'b0;
        @(posedge i_clk); #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0)
            begin errors++; $display("FAIL reset_no_accept: ready=%b valid=%b, want 1 0", bus.o_ready, bus.o_valid); end
    endtask

    task automatic test_basic();
        logic [7:0] d; logic o; int lat; logic p;
        run_op(8'h18, 8'h20, d, o, lat, p);
        checks++;
        if (d !== 8'h30 || o !== 1'b0) begin errors++; $display("FAIL basic_pos: data=%h ovf=%b, want 30 0", d, o); end
        checks++;
        if (lat !== 9) begin errors++; $display("FAIL basic_latency: got %0d, want 9", lat); end
        checks++;
        if (p !== 1'b1) begin errors++; $display("FAIL basic_pulse: got %b, want 1", p); end
        run_op(8'hE8, 8'h20, d, o, lat, p);
        checks++;
        if (d !== 8'hD0 || o !== 1'b0) begin errors++; $display("FAIL basic_neg: data=%h ovf=%b, want d0 0", d, o); end
    endtask

    task automatic test_saturation();
        logic [7:0] d; logic o; int lat; logic p;
        run_op(8'h7F, 8'h7F, d, o, lat, p);
        checks++;
        if (d !== 8'h7F || o !== 1'b1) begin errors++; $display("FAIL sat_7f7f: data=%h ovf=%b, want 7f 1", d, o); end
        run_op(8'h80, 8'h80, d, o, lat, p);
        checks++;
        if (d !== 8'h7F || o !== 1'b1) begin errors++; $display("FAIL sat_8080: data=%h ovf=%b, want 7f 1", d, o); end
        run_op(8'h80, 8'h10, d, o, lat, p);
        checks++;
        if (d !== 8'h80 || o !== 1'b0) begin errors++; $display("FAIL sat_neg_edge: data=%h ovf=%b, want 80 0", d, o); end
        run_op(8'h7F, 8'h80, d, o, lat, p);
        checks++;
        if (d !== 8'h80 || o !== 1'b1) begin errors++; $display("FAIL sat_neg: data=%h ovf=%b, want 80 1", d, o); end
    endtask

    task automatic test_truncation();
        logic [7:0] d; logic o; int lat; logic p;
        run_op(8'h01, 8'h01, d, o, lat, p);
        checks++;
        if (d !== 8'h00 || o !== 1'b0) begin errors++; $display("FAIL trunc_pos: data=%h ovf=%b, want 00 0", d, o); end
        run_op(8'hFF, 8'h01, d, o, lat, p);
        checks++;
        if (d !== 8'h00 || o !== 1'b0) begin errors++; $display("FAIL trunc_negzero: data=%h ovf=%b, want 00 0", d, o); end
        run_op(8'h18, 8'hF8, d, o, lat, p);
        checks++;
        if (d !== 8'hF4 || o !== 1'b0) begin errors++; $display("FAIL trunc_neg: data=%h ovf=%b, want f4 0", d, o); end
    endtask

    task automatic test_back_to_back();
        int last_acc = -1;
        int n_acc = 0;
        logic [7:0] exp_d = '0;
        logic exp_o = 1'b0;
        logic pending = 1'b0;
        logic prev_valid = 1'b0;
        for (int t = 0; t < 52; t++) begin
            if (bus.o_valid) begin
                checks++;
                if (!pending || bus.o_data !== exp_d || bus.o_overflow !== exp_o)
                    begin errors++; $display("FAIL b2b_result t=%0d: data=%h ovf=%b, want %h %b",
                        t, bus.o_data, bus.o_overflow, exp_d, exp_o); end
                pending = 1'b0;
            end
            if (prev_valid) begin
                checks++;
                if (bus.o_valid !== 1'b0) begin errors++; $display("FAIL b2b_pulse_width t=%0d: valid=%b, want 0", t, bus.o_valid); end
            end
            prev_valid = bus.o_valid;
            if (last_acc >= 0 && t == last_acc + 1) begin
                checks++;
                if (bus.o_ready !== 1'b0) begin errors++; $display("FAIL b2b_ready_low t=%0d: ready=%b, want 0", t, bus.o_ready); end
            end
            bus.i_valid = (t < 41);
            bus.i_a = 8'(t * 37 + 5);
            bus.i_b = 8'(t * 11 + 200);
            if (bus.o_ready && bus.i_valid) begin
                if (last_acc >= 0) begin
                    checks++;
                    if (t - last_acc !== 10) begin errors++; $display("FAIL b2b_spacing: got %0d, want 10", t - last_acc); end
                end
                last_acc = t;
                n_acc++;
                model(bus.i_a, bus.i_b, exp_d, exp_o);
                pending = 1'b1;
            end
            @(posedge i_clk); #1;
        end
        bus.i_valid = 1'b0;
        checks++;
        if (n_acc !== 5 || pending) begin errors++; $display("FAIL b2b_count: accepts=%0d pending=%b, want 5 0", n_acc, pending); end
    endtask

    task automatic test_reset_mid();
        int seen = 0;
        logic [7:0] d; logic o; int lat; logic p;
        bus.i_a = 8'h18; bus.i_b = 8'h20; bus.i_valid = 1'b1;
        @(posedge i_clk); #1;
        bus.i_valid = 1'b0;
        repeat (3) @(posedge i_clk);
        #3 i_reset = 1'b1;
        #1;
        checks++;
        if (bus.o_ready !== 1'b1 || bus.o_valid !== 1'b0 || bus.o_data !== 8'h00 || bus.o_overflow !== 1'b0)
            begin errors++; $display("FAIL reset_mid_outputs: ready=%b valid=%b data=%h ovf=%b, want 1 0 00 0",
                bus.o_ready, bus.o_valid, bus.o_data, bus.o_overflow); end
        @(posedge i_clk); #2;
        i_reset = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge i_clk); #1;
            if (bus.o_valid) seen++;
        end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL reset_mid_no_valid: pulses=%0d, want 0", seen); end
        run_op(8'h10, 8'h10, d, o, lat, p);
        checks++;
        if (d !== 8'h10 || o !== 1'b0 || lat !== 9) begin errors++; $display("FAIL reset_mid_fresh: data=%h ovf=%b lat=%0d, want 10 0 9", d, o, lat); end
    endtask

    task automatic test_random();
        logic [7:0] a, b, d, ed; logic o, eo; int lat; logic p;
        for (int i = 0; i < 1000; i++) begin
            a = 8'($urandom_range(0, 255));
            b = 8'($urandom_range(0, 255));
            model(a, b, ed, eo);
            run_op(a, b, d, o, lat, p);
            checks++;
            if (d !== ed || o !== eo || lat !== 9 || p !== 1'b1)
                begin errors++; $display("FAIL random a=%h b=%h: data=%h ovf=%b lat=%0d pulse=%b, want %h %b 9 1",
                    a, b, d, o, lat, p, ed, eo); end
        end
    endtask

    initial begin
        bus.i_valid = 1'b0; bus.i_a = '0; bus.i_b = '0;
        test_reset();
        test_basic();
        test_saturation();
        test_truncation();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/simple_fixed_point_signed_shift_add_multiplier.md
# simple_fixed_point_signed_shift_add_multiplier

Sequential signed fixed-point multiplier: the inverse operation to the team's long-division block and its natural companion in the fixed-point DSP filter chain. It accepts two signed Q(W−F).F operands via a valid/ready handshake and computes the product by iterative shift-add, one multiplier bit per clock. It then returns a truncated, saturated result of the same Q format, with an overflow flag.

## Interface
- DATA_WIDTH, 8, operand/result width W in bits (W ≥ 4).
- FRAC_BITS, 4, fractional bits F of operands and result (0 ≤ F < W).
- i_clk  input  1  clock; all state updates on rising edge.
- i_reset  input  1  reset, asynchronous, active-high.
- i_valid  input  1  operand pair present; accepted only when o_ready is high.
- i_a  input  DATA_WIDTH  signed multiplicand, Q(W−F).F two's complement.
- i_b  input  DATA_WIDTH  signed multiplier, Q(W−F).F two's complement.
- o_ready  output  1  block idle and able to accept operands.
- o_valid  output  1  one-cycle pulse: o_data/o_overflow hold a new result.
- o_data  output  DATA_WIDTH  signed product, Q(W−F).F, truncated toward zero, saturated.
- o_overflow  output  1  result was saturated; valid with o_valid, held afterwards.

## Operation
- States: IDLE, RUN, DONE.
- IDLE: o_ready=1. On an edge with i_valid=1, capture the operands:
  - |i_a| and |i_b| as W-bit unsigned magnitudes. |−2^(W−1)| = 2^(W−1) fits.
  - sign = i_a[W−1] XOR i_b[W−1].
  - Clear the 2W-bit accumulator and the bit counter; go to RUN.
- RUN: o_ready=0. Each edge:
  - If the current multiplier LSB is 1, add (multiplicand << count) into the accumulator.
  - Shift the multiplier right; increment count.
  - On the edge where count == W−1, finish the last bit and go to DONE.
  - RUN lasts exactly W edges.
- Result formation at the transition into DONE:
  - mag = accumulator >> F. Dropped bits are discarded, which truncates the magnitude toward zero.
  - Positive sign: if mag > 2^(W−1)−1, o_data = 2^(W−1)−1 and o_overflow=1; otherwise o_data = mag.
  - Negative sign: if mag > 2^(W−1), o_data = −2^(W−1) and o_overflow=1; otherwise o_data = −mag. mag = 0 gives 0x00, with no negative zero.
- DONE: o_valid=1 for exactly one cycle, o_ready=0. The next edge returns to IDLE.
- o_data and o_overflow hold their last values until the next DONE.
- i_valid outside IDLE is ignored: no queuing, no error.
- Operand changes after acceptance have no effect.

## Timing
- Reset values, applied asynchronously while i_reset=1: state IDLE, o_ready=1, o_valid=0, o_data=0, o_overflow=0, accumulator and counter 0.
- No operand is accepted on any edge while i_reset=1.
- Reset mid-RUN or in DONE: the operation is abandoned immediately; no o_valid pulse follows.
- Accept at edge k:
  - RUN occupies edges k+1 … k+W.
  - o_valid=1 in the cycle after edge k+W.
  - IDLE and o_ready=1 after edge k+W+1.
  - Earliest next accept: edge k+W+2.
- Latency from accept edge to o_valid: W+1 cycles (9 for W=8).
- Throughput: one product per W+2 cycles.
- All outputs are registered; there is no combinational path from inputs to outputs.

## Test plan
Defaults W=8, F=4 throughout.
- Basic: a=0x18 (1.5), b=0x20 (2.0) → o_valid 9 cycles after accept, o_data=0x30, o_overflow=0. Then a=0xE8 (−1.5), b=0x20 → 0xD0, o_overflow=0.
- Saturation:
  - a=0x7F, b=0x7F → 0x7F, o_overflow=1.
  - a=0x80, b=0x80 → 0x7F, o_overflow=1.
  - a=0x80, b=0x10 → 0x80, o_overflow=0 (exact −8.0 boundary).
- Truncation: a=0x01, b=0x01 → 0x00. a=0xFF, b=0x01 → 0x00, not 0xFF. a=0x18, b=0xF8 (−0.5) → 0xF4 (−0.75).
- Handshake:
  - Hold i_valid=1 continuously with changing operands → accepts spaced exactly 10 cycles.
  - Each o_valid is one cycle wide.
  - Operands changed during RUN do not alter the result.
  - o_ready is low from accept+1 through DONE.
- Reset mid-operation:
  - Assert i_reset asynchronously (not edge-aligned) 4 cycles into RUN → outputs 0 and o_ready=1 immediately; no o_valid afterwards.
  - A fresh a=0x10, b=0x10 after release → 0x10.
- Random: 1000 random operand pairs checked against a reference model (signed product, magnitude >> F, saturate), with latency checked every time.
